// File: rtl/mbist_data_cmp_log_if.sv
// rtl/mbist_data_cmp_log_if.sv - compare request bus from the MBIST pattern generator
interface mbist_data_cmp_log_if #(
  parameter int ADDR_WD = 9,
  parameter int DATA_WD = 32
);
  logic               compare;
  logic               read_invert;
  logic [DATA_WD-1:0] comp_data;
  logic [DATA_WD-1:0] rxd_data;
  logic [ADDR_WD-1:0] addr;

  modport master (output compare, read_invert, comp_data, rxd_data, addr);
  modport slave  (input  compare, read_invert, comp_data, rxd_data, addr);
endinterface

// File: rtl/mbist_data_cmp_log.sv
// rtl/mbist_data_cmp_log.sv - MBIST data comparator with unique failing-address log
module mbist_data_cmp_log #(
  parameter int BIST_ADDR_WD   = 9,
  parameter int BIST_DATA_WD   = 32,
  parameter int BIST_ERR_LIMIT = 4,
  localparam int CNT_WD        = $clog2(BIST_ERR_LIMIT + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  mbist_data_cmp_log_if.slave     bus,
  input  logic [CNT_WD-1:0]       log_rd_idx,
  output logic                    error,
  output logic                    error_fix,
  output logic                    correct,
  output logic [BIST_ADDR_WD-1:0] error_addr,
  output logic [BIST_DATA_WD-1:0] fail_bits,
  output logic [CNT_WD-1:0]       err_cnt,
  output logic [BIST_ADDR_WD-1:0] log_rd_addr
);

  logic [BIST_DATA_WD-1:0] diff_q;
  logic                    fail_q;
  logic                    vld_q;
  logic [BIST_ADDR_WD-1:0] addr_q;
  logic [BIST_ADDR_WD-1:0] entry [BIST_ERR_LIMIT];
  logic [BIST_ERR_LIMIT-1:0] entry_vld;

  logic [BIST_DATA_WD-1:0] exp_data;
  logic [BIST_DATA_WD-1:0] diff_d;
  logic                    hit;
  logic                    full;
  logic                    stage2;

  assign exp_data = bus.read_invert ? ~bus.comp_data : bus.comp_data;
  assign diff_d   = exp_data ^ bus.rxd_data;
  assign full     = (err_cnt == CNT_WD'(BIST_ERR_LIMIT));
  assign stage2   = vld_q & fail_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
      fail_q <= 1'b0;
      vld_q  <= 1'b0;
      addr_q <= '0;
    end else if (clr) begin
      diff_q <= '0;
      fail_q <= 1'b0;
      vld_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      vld_q <= bus.compare;
      if (bus.compare) begin
        diff_q <= diff_d;
        fail_q <= |diff_d;
        addr_q <= bus.addr;
      end else begin
        fail_q <= 1'b0;
      end
    end
  end

  // Hit check reads the registered log, so an entry written at the previous
  // edge is already visible to a back-to-back compare of the same address.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < BIST_ERR_LIMIT; i++) begin
      if (entry_vld[i] && (entry[i] == addr_q)) hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error      <= 1'b0;
      error_fix  <= 1'b0;
      correct    <= 1'b0;
      error_addr <= '0;
      fail_bits  <= '0;
      err_cnt    <= '0;
      entry_vld  <= '0;
      for (int i = 0; i < BIST_ERR_LIMIT; i++) entry[i] <= '0;
    end else if (clr) begin
      error      <= 1'b0;
      error_fix  <= 1'b0;
      correct    <= 1'b0;
      error_addr <= '0;
      fail_bits  <= '0;
      err_cnt    <= '0;
      entry_vld  <= '0;
      for (int i = 0; i < BIST_ERR_LIMIT; i++) entry[i] <= '0;
    end else begin
      error_fix <= 1'b0;
      if (stage2) begin
        fail_bits  <= fail_bits | diff_q;
        error_addr <= addr_q;
        if (hit) begin
          error_fix <= 1'b1;
        end else if (!full) begin
          for (int i = 0; i < BIST_ERR_LIMIT; i++) begin
            if (CNT_WD'(i) == err_cnt) begin
              entry[i]     <= addr_q;
              entry_vld[i] <= 1'b1;
            end
          end
          err_cnt   <= err_cnt + CNT_WD'(1);
          error_fix <= 1'b1;
          correct   <= 1'b1;
        end else begin
          error <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    log_rd_addr = '0;
    for (int i = 0; i < BIST_ERR_LIMIT; i++) begin
      if ((CNT_WD'(i) == log_rd_idx) && (log_rd_idx < err_cnt)) log_rd_addr = entry[i];
    end
  end

endmodule

// File: tb/tb_mbist_data_cmp_log.sv
// tb/tb_mbist_data_cmp_log.sv - directed table-driven bench for mbist_data_cmp_log
module tb_mbist_data_cmp_log;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [CW-1:0] log_rd_idx = '0;
  logic          error, error_fix, correct;
  logic [AW-1:0] error_addr, log_rd_addr;
  logic [DW-1:0] fail_bits;
  logic [CW-1:0] err_cnt;

  mbist_data_cmp_log_if #(.ADDR_WD(AW), .DATA_WD(DW)) bus ();

  mbist_data_cmp_log #(.BIST_ADDR_WD(AW), .BIST_DATA_WD(DW), .BIST_ERR_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus), .log_rd_idx(log_rd_idx),
    .error(error), .error_fix(error_fix), .correct(correct), .error_addr(error_addr),
    .fail_bits(fail_bits), .err_cnt(err_cnt), .log_rd_addr(log_rd_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          clr, cmp, inv;
    logic [DW-1:0] comp, rxd;
    logic [AW-1:0] addr;
    logic [CW-1:0] idx;
    logic          e_err, e_fix, e_cor;
    logic [CW-1:0] e_cnt;
    logic [DW-1:0] e_fb;
    logic [AW-1:0] e_ea, e_lra;
  } vec_t;

  vec_t vec [22];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(logic c, logic cm, logic iv, logic [DW-1:0] cp, logic [DW-1:0] rx,
                              logic [AW-1:0] a, logic [CW-1:0] ix, logic ee, logic ef, logic ec,
                              logic [CW-1:0] en, logic [DW-1:0] fb, logic [AW-1:0] ea,
                              logic [AW-1:0] lr);
    vec_t v;
    v.clr = c; v.cmp = cm; v.inv = iv; v.comp = cp; v.rxd = rx; v.addr = a; v.idx = ix;
    v.e_err = ee; v.e_fix = ef; v.e_cor = ec; v.e_cnt = en; v.e_fb = fb; v.e_ea = ea; v.e_lra = lr;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic ee, logic ef, logic ec, logic [CW-1:0] en,
                         logic [DW-1:0] fb, logic [AW-1:0] ea);
    n_vec++;
    chk({tag, ".error"}, 32'(error), 32'(ee));
    chk({tag, ".error_fix"}, 32'(error_fix), 32'(ef));
    chk({tag, ".correct"}, 32'(correct), 32'(ec));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(en));
    chk({tag, ".fail_bits"}, fail_bits, fb);
    chk({tag, ".error_addr"}, 32'(error_addr), 32'(ea));
  endtask

  task automatic drive(logic c, logic cm, logic iv, logic [DW-1:0] cp, logic [DW-1:0] rx,
                       logic [AW-1:0] a);
    clr = c; bus.compare = cm; bus.read_invert = iv;
    bus.comp_data = cp; bus.rxd_data = rx; bus.addr = a;
  endtask

  initial begin
    //          clr cmp inv comp          rxd           addr   idx  err fix cor cnt fb            ea     lra
    vec[0]  = mk(0, 1, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 9'h010, 3'd0, 0, 0, 0, 3'd0, 32'h0,        9'h000, 9'h000);
    vec[1]  = mk(0, 0, 0, 32'h0,        32'h0,        9'h000, 3'd0, 0, 0, 0, 3'd0, 32'h0,        9'h000, 9'h000);
    vec[2]  = mk(0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, 9'h020, 3'd0, 0, 0, 0, 3'd0, 32'h0,        9'h000, 9'h000);
    vec[3]  = mk(0, 0, 0, 32'h0,        32'h0,        9'h000, 3'd0, 0, 1, 1, 3'd1, 32'h1,        9'h020, 9'h020);
    vec[4]  = mk(0, 1, 0, 32'h0,        32'h100,      9'h030, 3'd0, 0, 0, 1, 3'd1, 32'h1,        9'h020, 9'h020);
    vec[5]  = mk(0, 1, 0, 32'h0,        32'h100,      9'h030, 3'd1, 0, 1, 1, 3'd2, 32'h101,      9'h030, 9'h030);
    vec[6]  = mk(0, 1, 0, 32'h0,        32'h100,      9'h030, 3'd1, 0, 1, 1, 3'd2, 32'h101,      9'h030, 9'h030);
    vec[7]  = mk(0, 0, 0, 32'h0,        32'h0,        9'h000, 3'd1, 0, 1, 1, 3'd2, 32'h101,      9'h030, 9'h030);
    vec[8]  = mk(0, 0, 0, 32'h0,        32'h0,        9'h000, 3'd1, 0, 0, 1, 3'd2, 32'h101,      9'h030, 9'h030);
    vec[9]  = mk(1, 0, 0, 32'h0,        32'h0,        9'h000, 3'd0, 0, 0, 0, 3'd0, 32'h0,        9'h000, 9'h000);
    vec[10] = mk(0, 1, 1, 32'h0000FFFF, 32'hFFFF0000, 9'h040, 3'd0, 0, 0, 0, 3'd0, 32'h0,        9'h000, 9'h000);
    vec[11] = mk(0, 1, 1, 32'h0000FFFF, 32'hFFFF0001, 9'h040, 3'd0, 0, 0, 0, 3'd0, 32'h0,        9'h000, 9'h000);
    vec[12] = mk(0, 0, 0, 32'h0,        32'h0,        9'h000, 3'd0, 0, 1, 1, 3'd1, 32'h1,        9'h040, 9'h040);
    vec[13] = mk(1, 1, 0, 32'h0,        32'hFF,       9'h099, 3'd0, 0, 0, 0, 3'd0, 32'h0,        9'h000, 9'h000);
    vec[14] = mk(0, 1, 0, 32'h0,        32'h80000000, 9'h001, 3'd0, 0, 0, 0, 3'd0, 32'h0,        9'h000, 9'h000);
    vec[15] = mk(0, 1, 0, 32'h0,        32'h80000000, 9'h002, 3'd0, 0, 1, 1, 3'd1, 32'h80000000, 9'h001, 9'h001);
    vec[16] = mk(0, 1, 0, 32'h0,        32'h80000000, 9'h003, 3'd1, 0, 1, 1, 3'd2, 32'h80000000, 9'h002, 9'h002);
    vec[17] = mk(0, 1, 0, 32'h0,        32'h80000000, 9'h004, 3'd2, 0, 1, 1, 3'd3, 32'h80000000, 9'h003, 9'h003);
    vec[18] = mk(0, 1, 0, 32'h0,        32'h80000000, 9'h005, 3'd3, 0, 1, 1, 3'd4, 32'h80000000, 9'h004, 9'h004);
    vec[19] = mk(0, 1, 0, 32'h0,        32'h80000000, 9'h002, 3'd4, 1, 0, 1, 3'd4, 32'h80000000, 9'h005, 9'h000);
    vec[20] = mk(0, 0, 0, 32'h0,        32'h0,        9'h000, 3'd1, 1, 1, 1, 3'd4, 32'h80000000, 9'h002, 9'h002);
    vec[21] = mk(0, 0, 0, 32'h0,        32'h0,        9'h000, 3'd0, 1, 0, 1, 3'd4, 32'h80000000, 9'h002, 9'h001);

    drive(0, 0, 0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 3'd0, 32'h0, 9'h000);
    chk("reset.log_rd_addr", 32'(log_rd_addr), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      drive(vec[i].clr, vec[i].cmp, vec[i].inv, vec[i].comp, vec[i].rxd, vec[i].addr);
      log_rd_idx = vec[i].idx;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vec[i].e_err, vec[i].e_fix, vec[i].e_cor, vec[i].e_cnt,
              vec[i].e_fb, vec[i].e_ea);
      chk($sformatf("vec%0d.log_rd_addr", i), 32'(log_rd_addr), 32'(vec[i].e_lra));
    end

    // clr while a failing compare sits in stage 1
    log_rd_idx = 3'd0;
    drive(0, 1, 0, 32'h0, 32'h1, 9'h050);
    @(posedge clk); #1;
    drive(1, 0, 0, '0, '0, '0);
    @(posedge clk); #1;
    chk_all("clr_mid", 0, 0, 0, 3'd0, 32'h0, 9'h000);
    drive(0, 0, 0, '0, '0, '0);
    @(posedge clk); #1;
    chk_all("clr_after", 0, 0, 0, 3'd0, 32'h0, 9'h000);
    chk("clr_after.log_rd_addr", 32'(log_rd_addr), 32'h0);

    // async reset in the middle of a failing burst
    drive(0, 1, 0, 32'h0, 32'h4, 9'h060);
    @(posedge clk); #1;
    drive(0, 1, 0, 32'h0, 32'h4, 9'h061);
    @(posedge clk); #1;
    chk_all("burst_pre", 0, 1, 1, 3'd1, 32'h4, 9'h060);
    drive(0, 1, 0, 32'h0, 32'h4, 9'h062);
    #2 rst_n = 1'b0;
    #1;
    chk_all("rst_mid", 0, 0, 0, 3'd0, 32'h0, 9'h000);
    drive(0, 0, 0, '0, '0, '0);
    #2 rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk_all("rst_after", 0, 0, 0, 3'd0, 32'h0, 9'h000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
